// File: rtl/posit_pkg.sv
// Shared posit decoder widths, result record and NaR helper.
// The record is sized for the default (8,2) format; other formats size ports from N/ES directly.
package posit_pkg;

    localparam int unsigned POSIT_N_DEF  = 8;
    localparam int unsigned POSIT_ES_DEF = 2;

    function automatic int unsigned posit_sw(input int unsigned n, input int unsigned es);
        return $clog2(n) + es + 1;
    endfunction

    function automatic int unsigned posit_mw(input int unsigned n);
        return n - 2;
    endfunction

    localparam int unsigned POSIT_SW = posit_sw(POSIT_N_DEF, POSIT_ES_DEF);
    localparam int unsigned POSIT_MW = posit_mw(POSIT_N_DEF);

    typedef struct packed {
        logic                       sign;
        logic                       nar;
        logic                       zero;
        logic signed [POSIT_SW-1:0] scale;
        logic [POSIT_MW-1:0]        mant;
    } posit_dec_t;

    // NaR is the sign bit alone: bit n-1 set, every lower bit clear.
    function automatic logic posit_is_nar(input logic [63:0] p, input int unsigned n);
        logic low_zero;
        low_zero = 1'b1;
        for (int unsigned i = 0; i < 64; i++) begin
            if ((i < n - 1) && p[i]) begin
                low_zero = 1'b0;
            end
        end
        return p[n-1] && low_zero;
    endfunction

endpackage

// File: rtl/posit_regime_lzd.sv
// Regime run detector: length of the leading run of bits equal to the top bit of the magnitude.
module posit_regime_lzd
    import posit_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned RS = $clog2(N)
) (
    input  logic [N-2:0] in,
    output logic         r,
    output logic [RS:0]  m
);

    localparam logic [RS:0] ONE = (RS + 1)'(1);

    logic run;

    always_comb begin
        r   = in[N-2];
        m   = ONE;
        run = 1'b1;
        for (int unsigned i = 1; i < N - 1; i++) begin
            if (run && (in[N-2-i] == r)) begin
                m = m + ONE;
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/posit_decode_pipe.sv
// Two-stage posit decoder: stage 1 takes magnitude and regime run, stage 2 shifts out
// exponent/fraction and forms the signed scale. Valid/ready with full throughput.
module posit_decode_pipe
    import posit_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned ES = 2,
    parameter int unsigned RS = $clog2(N),
    localparam int unsigned SW = RS + ES + 1,
    localparam int unsigned MW = N - 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_posit,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sign,
    output logic                 out_nar,
    output logic                 out_zero,
    output logic signed [SW-1:0] out_scale,
    output logic [MW-1:0]        out_mant
);

    localparam logic [RS:0]   ONE_M  = (RS + 1)'(1);
    localparam logic [SW-1:0] ONE_SW = SW'(1);

    logic s2_adv, s1_adv, accept;

    logic [N-2:0] in_low, in_mag;
    logic         in_nar, in_zero;
    logic         lzd_r;
    logic [RS:0]  lzd_m;

    logic         s1_valid_q, s1_valid_d;
    logic         s1_sign_q,  s1_sign_d;
    logic         s1_nar_q,   s1_nar_d;
    logic         s1_zero_q,  s1_zero_d;
    logic [N-2:0] s1_mag_q,   s1_mag_d;
    logic         s1_r_q,     s1_r_d;
    logic [RS:0]  s1_m_q,     s1_m_d;

    logic                 out_valid_q, out_valid_d;
    logic                 out_sign_q,  out_sign_d;
    logic                 out_nar_q,   out_nar_d;
    logic                 out_zero_q,  out_zero_d;
    logic signed [SW-1:0] out_scale_q, out_scale_d;
    logic [MW-1:0]        out_mant_q,  out_mant_d;

    logic [RS:0]          sh;
    logic [N-2:0]         rem, frac_al;
    logic [SW-1:0]        m_ext;
    logic signed [SW-1:0] k_s, e_ext, scale_c;
    logic [MW-1:0]        mant_c;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign accept   = in_valid && s1_adv;

    assign in_low  = in_posit[N-2:0];
    assign in_mag  = in_posit[N-1] ? -in_low : in_low;
    assign in_nar  = posit_is_nar(64'(in_posit), N);
    assign in_zero = (in_posit == '0);

    posit_regime_lzd #(
        .N  (N),
        .RS (RS)
    ) u_lzd (
        .in (in_mag),
        .r  (lzd_r),
        .m  (lzd_m)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_nar_d   = s1_nar_q;
        s1_zero_d  = s1_zero_q;
        s1_mag_d   = s1_mag_q;
        s1_r_d     = s1_r_q;
        s1_m_d     = s1_m_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
        end
        if (accept) begin
            s1_sign_d = in_posit[N-1];
            s1_nar_d  = in_nar;
            s1_zero_d = in_zero;
            s1_mag_d  = in_mag;
            s1_r_d    = lzd_r;
            s1_m_d    = lzd_m;
        end
    end

    // Dropping the regime and its terminator leaves exponent then fraction at the top of rem.
    always_comb begin
        sh      = s1_m_q + ONE_M;
        rem     = s1_mag_q << sh;
        frac_al = rem << ES;
        m_ext   = SW'(s1_m_q);
        k_s     = s1_r_q ? (m_ext - ONE_SW) : -m_ext;
        scale_c = (k_s <<< ES) + e_ext;
        mant_c  = {1'b1, (N - 3)'(frac_al >> 2)};
    end

    if (ES > 0) begin : g_exp
        assign e_ext = SW'(rem[N-2 -: ES]);
    end else begin : g_no_exp
        assign e_ext = '0;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_sign_d  = out_sign_q;
        out_nar_d   = out_nar_q;
        out_zero_d  = out_zero_q;
        out_scale_d = out_scale_q;
        out_mant_d  = out_mant_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_sign_d = s1_sign_q;
                out_nar_d  = s1_nar_q;
                out_zero_d = s1_zero_q;
                if (s1_nar_q || s1_zero_q) begin
                    out_scale_d = '0;
                    out_mant_d  = '0;
                end else begin
                    out_scale_d = scale_c;
                    out_mant_d  = mant_c;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_nar_q    <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_mag_q    <= '0;
            s1_r_q      <= 1'b0;
            s1_m_q      <= '0;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_nar_q   <= 1'b0;
            out_zero_q  <= 1'b0;
            out_scale_q <= '0;
            out_mant_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_nar_q    <= s1_nar_d;
            s1_zero_q   <= s1_zero_d;
            s1_mag_q    <= s1_mag_d;
            s1_r_q      <= s1_r_d;
            s1_m_q      <= s1_m_d;
            out_valid_q <= out_valid_d;
            out_sign_q  <= out_sign_d;
            out_nar_q   <= out_nar_d;
            out_zero_q  <= out_zero_d;
            out_scale_q <= out_scale_d;
            out_mant_q  <= out_mant_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sign  = out_sign_q;
    assign out_nar   = out_nar_q;
    assign out_zero  = out_zero_q;
    assign out_scale = out_scale_q;
    assign out_mant  = out_mant_q;

endmodule
